// File: rtl/sample_ram.sv
// Sample storage for pcm_fifo: DEPTH x 16, one synchronous write port and one
// synchronous read port with read enable, so the read register holds between pops.
module sample_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pcm_fifo.sv
// CPU-fed PCM sample FIFO: byte-wise little-endian sample assembly on the write side,
// one sample per clken on the audio side, with sticky overflow/underrun flags.
module pcm_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        adr,
  input  logic [7:0]  data,
  input  logic        clken,
  output logic [15:0] sound_out,
  output logic [8:0]  status,
  output logic        empty,
  output logic        full
);

  localparam int FLUSH   = 0;
  localparam int CLRFLAG = 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level, level_nxt;
  logic          phase;
  logic [7:0]    lo_byte;
  logic          overflow, underrun;
  logic          out_zero;
  logic [6:0]    level_sat, level_sat_nxt;
  logic [15:0]   ram_q;

  logic data_wr, ctrl_wr, flush, clr;
  logic push_req, push, pop_req, pop;

  always_comb begin
    data_wr  = wr & ~adr;
    ctrl_wr  = wr & adr;
    flush    = ctrl_wr & data[FLUSH];
    clr      = ctrl_wr & data[CLRFLAG];
    push_req = data_wr & phase;
    push     = push_req & ~full;
    pop_req  = clken & ~flush;
    pop      = pop_req & ~empty;

    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + (AW+1)'(1);
      2'b01:   level_nxt = level - (AW+1)'(1);
      default: level_nxt = level;
    endcase

    if (int'(level_nxt) > 127) level_sat_nxt = 7'd127;
    else                       level_sat_nxt = 7'(int'(level_nxt));
  end

  // rd_ptr always addresses the oldest sample, so the RAM read register is the output
  sample_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push & ~reset),
    .waddr (wr_ptr),
    .wdata ({data, lo_byte}),
    .re    (pop & ~reset),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      level_sat <= '0;
      phase     <= 1'b0;
      lo_byte   <= '0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
      out_zero  <= 1'b1;
      empty     <= 1'b1;
      full      <= 1'b0;
    end else begin
      if (data_wr) begin
        phase <= ~phase;
        if (!phase) lo_byte <= data;
      end

      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        level_sat <= '0;
        phase     <= 1'b0;
        out_zero  <= 1'b1;
        empty     <= 1'b1;
        full      <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + AW'(1);
          out_zero <= 1'b0;
        end else if (pop_req) begin
          out_zero <= 1'b1;
        end
        level     <= level_nxt;
        level_sat <= level_sat_nxt;
        empty     <= (level_nxt == '0);
        full      <= (level_nxt == (AW+1)'(DEPTH));
      end

      // an event in the same cycle as a clear wins
      overflow <= (overflow & ~clr) | (push_req & full);
      underrun <= (underrun & ~clr) | (pop_req & empty);
    end
  end

  assign sound_out = out_zero ? 16'h0000 : ram_q;
  assign status    = {overflow, underrun, level_sat};

endmodule

// File: tb/tb_pcm_fifo.sv
// Bench for pcm_fifo: constant vector table, directed corner sequences and a
// randomized run against a queue-based model.
module tb_pcm_fifo;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        reset, wr, adr, clken;
  logic [7:0]  data;
  logic [15:0] sound_out;
  logic [8:0]  status;
  logic        empty, full;

  pcm_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr(wr), .adr(adr), .data(data), .clken(clken),
    .sound_out(sound_out), .status(status), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  string tag = "init";

  logic [15:0] mq[$];
  logic        m_phase;
  logic [7:0]  m_lo;
  logic        m_ovf, m_unr;
  logic [15:0] m_out;

  typedef struct {
    logic        w, a;
    logic [7:0]  d;
    logic        ck;
    logic [15:0] so;
    logic [8:0]  st;
    logic        em, fu;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    int lvl;
    int sat;
    lvl = mq.size();
    sat = (lvl > 127) ? 127 : lvl;
    chk({tag, ".sound_out"}, 32'(sound_out), 32'(m_out));
    chk({tag, ".status"}, 32'(status), 32'({m_ovf, m_unr, 7'(sat)}));
    chk({tag, ".empty_full"}, 32'({empty, full}), 32'({lvl == 0, lvl == DEPTH}));
  endtask

  task automatic model_step(input logic r, input logic w, input logic a,
                            input logic [7:0] d, input logic ck);
    logic ov_s, un_s, fl, cl, have_push;
    logic [15:0] ps;
    int sz;
    ov_s = 0; un_s = 0; fl = 0; cl = 0; have_push = 0; ps = '0;
    if (r) begin
      mq.delete(); m_phase = 0; m_lo = 0; m_ovf = 0; m_unr = 0; m_out = 0;
    end else begin
      sz = mq.size();
      if (w && !a) begin
        if (m_phase) begin
          if (sz == DEPTH) ov_s = 1;
          else begin have_push = 1; ps = {d, m_lo}; end
        end else m_lo = d;
        m_phase = ~m_phase;
      end
      if (w && a) begin fl = d[0]; cl = d[1]; end
      if (ck && !fl) begin
        if (sz > 0) m_out = mq.pop_front();
        else begin m_out = 16'h0000; un_s = 1; end
      end
      if (have_push) mq.push_back(ps);
      if (fl) begin mq.delete(); m_phase = 0; m_out = 16'h0000; end
      if (cl) begin m_ovf = 0; m_unr = 0; end
      if (ov_s) m_ovf = 1;
      if (un_s) m_unr = 1;
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic a,
                     input logic [7:0] d, input logic ck);
    reset = r; wr = w; adr = a; data = d; clken = ck;
    model_step(r, w, a, d, ck);
    @(posedge clk);
    #1;
    reset = 0; wr = 0; adr = 0; data = 0; clken = 0;
    check_model();
  endtask

  task automatic push_sample(input logic [15:0] s);
    cyc(0, 1, 0, s[7:0], 0);
    cyc(0, 1, 0, s[15:8], 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 8'h00, 0);
  endtask

  initial begin
    reset = 1; wr = 0; adr = 0; data = 0; clken = 0;
    m_phase = 0; m_lo = 0; m_ovf = 0; m_unr = 0; m_out = 0;

    //            w  a  d      ck  so        st      em  fu
    tbl[0] = '{1, 0, 8'h34, 0, 16'h0000, 9'h000, 1, 0};
    tbl[1] = '{1, 0, 8'h12, 0, 16'h0000, 9'h001, 0, 0};
    tbl[2] = '{1, 0, 8'h78, 0, 16'h0000, 9'h001, 0, 0};
    tbl[3] = '{1, 0, 8'h56, 0, 16'h0000, 9'h002, 0, 0};
    tbl[4] = '{0, 0, 8'h00, 1, 16'h1234, 9'h001, 0, 0};
    tbl[5] = '{0, 0, 8'h00, 1, 16'h5678, 9'h000, 1, 0};
    tbl[6] = '{0, 0, 8'h00, 0, 16'h5678, 9'h000, 1, 0};
    tbl[7] = '{0, 0, 8'h00, 1, 16'h0000, 9'h080, 1, 0};
    tbl[8] = '{0, 0, 8'h00, 0, 16'h0000, 9'h080, 1, 0};
    tbl[9] = '{1, 1, 8'h02, 0, 16'h0000, 9'h000, 1, 0};

    tag = "reset";
    do_reset();
    do_reset();
    chk("reset_state", 32'({sound_out, status, empty, full}), 32'({16'h0000, 9'h000, 2'b10}));

    tag = "table";
    for (int i = 0; i < 10; i++) begin
      cyc(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ck);
      chk($sformatf("vec%0d", i), 32'({sound_out, status, empty, full}),
          32'({tbl[i].so, tbl[i].st, tbl[i].em, tbl[i].fu}));
    end

    tag = "overflow";
    do_reset();
    for (int i = 0; i < 64; i++) push_sample(16'h1000 + 16'(i));
    chk("ovf_full64", 32'({status, empty, full}), 32'({9'h040, 2'b01}));
    push_sample(16'hdead);
    chk("ovf_65th", 32'({status, full}), 32'({9'h140, 1'b1}));
    for (int i = 0; i < 64; i++) begin
      cyc(0, 0, 0, 8'h00, 1);
      chk($sformatf("ovf_pop%0d", i), 32'(sound_out), 32'(16'h1000 + 16'(i)));
    end
    chk("ovf_drained", 32'({status, empty}), 32'({9'h100, 1'b1}));

    tag = "pushpop";
    do_reset();
    for (int i = 0; i < 5; i++) push_sample(16'h2000 + 16'(i));
    cyc(0, 1, 0, 8'h55, 0);
    cyc(0, 1, 0, 8'h66, 1);
    chk("pp_level5", 32'({sound_out, status}), 32'({16'h2000, 9'h005}));
    for (int i = 0; i < 59; i++) push_sample(16'h3000 + 16'(i));
    chk("pp_full", 32'({status, full}), 32'({9'h040, 1'b1}));
    cyc(0, 1, 0, 8'h77, 0);
    cyc(0, 1, 0, 8'h88, 1);
    chk("pp_at_full", 32'({sound_out, status, full}), 32'({16'h2001, 9'h13f, 1'b0}));

    tag = "flush_mid";
    do_reset();
    cyc(0, 1, 0, 8'hab, 0);
    cyc(0, 1, 1, 8'h01, 0);
    cyc(0, 1, 0, 8'h11, 0);
    cyc(0, 1, 0, 8'h22, 0);
    cyc(0, 0, 0, 8'h00, 1);
    chk("flush_mid_sample", 32'(sound_out), 32'(16'h2211));
    push_sample(16'h4242);
    cyc(0, 1, 1, 8'h03, 1);
    chk("flush_beats_clken", 32'({sound_out, status}), 32'({16'h0000, 9'h000}));

    tag = "reset_mid";
    do_reset();
    for (int i = 0; i < 11; i++) push_sample(16'h5000 + 16'(i));
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 1, 0, 8'h99, 0);
    cyc(1, 1, 0, 8'hee, 1);
    chk("reset_mid_state", 32'({sound_out, status, empty, full}), 32'({16'h0000, 9'h000, 2'b10}));
    cyc(0, 1, 0, 8'h33, 0);
    cyc(0, 1, 0, 8'h44, 0);
    cyc(0, 0, 0, 8'h00, 1);
    chk("reset_mid_next", 32'(sound_out), 32'(16'h4433));

    tag = "random";
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic r, w, a, ck;
      logic [7:0] d;
      int ckpct;
      ckpct = (n < 1200) ? 10 : 55;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 99) < 60);
      a  = w && ($urandom_range(0, 19) == 0);
      d  = a ? 8'($urandom_range(0, 3)) : 8'($urandom);
      ck = ($urandom_range(0, 99) < ckpct);
      cyc(r, w, a, d, ck);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
